// File: rtl/qos_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// qos_arbiter_pkg
// Shared constants, FSM state type and a saturating-increment helper for the
// QoS virtual-channel arbiter and its round-robin selector.
// ---------------------------------------------------------------------------
package qos_arbiter_pkg;

    localparam int DATA_W   = 12;
    localparam int NUM_VC   = 4;
    localparam int DEST_LSB = 8;
    localparam int DEST_MSB = 9;
    localparam int CNT_W    = 8;

    // IDLE: nothing was granted this cycle; SERVE: a word was granted.
    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/qos_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Purely combinational round-robin picker over four requesters.
// The search begins at lastGrant+1 (mod 4) and walks upward with wrap, so the
// previously served VC is the last one considered.
//
// Ports
//   eligible     in  [3:0]  per-VC request (already qualified by the caller)
//   last_grant   in  [1:0]  index of the most recent grant
//   grant_onehot out [3:0]  one-hot grant, zero when nothing is eligible
//   grant_idx    out [1:0]  binary index of the grant (last_grant when none)
//   any_grant    out        high when some VC was chosen
// ---------------------------------------------------------------------------
module rr_select
    import qos_arbiter_pkg::*;
(
    input  logic [NUM_VC-1:0] eligible,
    input  logic [1:0]        last_grant,
    output logic [NUM_VC-1:0] grant_onehot,
    output logic [1:0]        grant_idx,
    output logic              any_grant
);

    logic [1:0] w_cand;

    // Walk the four candidates in priority order and keep the first hit.
    // The 2-bit add wraps naturally, and the fourth step lands back on
    // last_grant so a lone requester is still served every cycle.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = last_grant;
        any_grant    = 1'b0;
        w_cand       = '0;
        for (int k = 1; k <= NUM_VC; k++) begin
            w_cand = last_grant + 2'(k);
            if (!any_grant && eligible[w_cand]) begin
                any_grant            = 1'b1;
                grant_idx            = w_cand;
                grant_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qos_arbiter.sv
// ---------------------------------------------------------------------------
// qos_arbiter
// Round-robin arbiter draining four first-word-fall-through VC FIFOs into one
// registered output stream. A VC whose head word targets an almost-full
// destination is skipped that cycle without stalling the others.
//
// Ports
//   clk               in       clock, all state on the rising edge
//   reset             in       synchronous, active-high
//   fifo_empty        in  [3:0] per-VC empty flags
//   fifo_data0..3     in  [11:0] head word of each VC (dest in bits [9:8])
//   dest_almost_full  in  [3:0] downstream back-pressure, indexed by dest
//   pop               out [3:0] one-hot pop strobe (combinational)
//   arb_out           out [11:0] registered granted word, zero when idle
//   arb_valid         out       arb_out holds a freshly granted word
//
// Optional build macro QOS_ARB_STATS_EN adds:
//   grant_cnt0..3     out [7:0] saturating per-VC grant counters
//   blocked_cnt       out [7:0] saturating count of back-pressured cycles
// ---------------------------------------------------------------------------
module qos_arbiter
    import qos_arbiter_pkg::*;
#(
    parameter int DATA_W = qos_arbiter_pkg::DATA_W,
    parameter int NUM_VC = qos_arbiter_pkg::NUM_VC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_VC-1:0] fifo_empty,
    input  logic [DATA_W-1:0] fifo_data0,
    input  logic [DATA_W-1:0] fifo_data1,
    input  logic [DATA_W-1:0] fifo_data2,
    input  logic [DATA_W-1:0] fifo_data3,
    input  logic [NUM_VC-1:0] dest_almost_full,
    output logic [NUM_VC-1:0] pop,
    output logic [DATA_W-1:0] arb_out,
    output logic              arb_valid
`ifdef QOS_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic [CNT_W-1:0]  grant_cnt2,
    output logic [CNT_W-1:0]  grant_cnt3,
    output logic [CNT_W-1:0]  blocked_cnt
`endif
);

    logic [DATA_W-1:0] w_data [NUM_VC];
    logic [1:0]        w_dest [NUM_VC];
    logic [NUM_VC-1:0] w_eligible;
    logic [NUM_VC-1:0] w_grantOnehot;
    logic [1:0]        w_grantIdx;
    logic              w_anyGrant;

    arb_state_t        r_state;
    logic [DATA_W-1:0] r_arbOut;
    logic [1:0]        r_lastGrant;

    assign w_data[0] = fifo_data0;
    assign w_data[1] = fifo_data1;
    assign w_data[2] = fifo_data2;
    assign w_data[3] = fifo_data3;

    // A VC may compete only if it has a word, its head's destination is not
    // back-pressured this very cycle, and we are not in reset. Gating reset
    // here keeps pop low during reset without a separate output mask.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            w_dest[i]     = w_data[i][DEST_MSB:DEST_LSB];
            w_eligible[i] = !reset && !fifo_empty[i] && !dest_almost_full[w_dest[i]];
        end
    end

    rr_select u_rrSelect (
        .eligible     (w_eligible),
        .last_grant   (r_lastGrant),
        .grant_onehot (w_grantOnehot),
        .grant_idx    (w_grantIdx),
        .any_grant    (w_anyGrant)
    );

    assign pop = w_grantOnehot;

    // Two-state FSM that also registers the output word. Reset leaves the
    // round-robin pointer at 3 so VC0 is searched first afterwards; idle
    // cycles flush the output to zero but keep the pointer where it was.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_arbOut    <= '0;
            r_lastGrant <= 2'd3;
        end else if (w_anyGrant) begin
            r_state     <= SERVE;
            r_arbOut    <= w_data[w_grantIdx];
            r_lastGrant <= w_grantIdx;
        end else begin
            r_state     <= IDLE;
            r_arbOut    <= '0;
        end
    end

    assign arb_out   = r_arbOut;
    assign arb_valid = (r_state == SERVE);

`ifdef QOS_ARB_STATS_EN
    logic [CNT_W-1:0] r_grantCnt [NUM_VC];
    logic [CNT_W-1:0] r_blockedCnt;
    logic             w_anyBlocked;

    // A cycle counts as blocked when some VC holds data but its destination
    // is almost full, regardless of whether another VC was granted.
    always_comb begin
        w_anyBlocked = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!fifo_empty[i] && dest_almost_full[w_dest[i]]) begin
                w_anyBlocked = 1'b1;
            end
        end
    end

    // Saturating statistics; they stop at 255 rather than wrapping so a
    // long run never reads back as a small number.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_grantCnt[i] <= '0;
            end
            r_blockedCnt <= '0;
        end else begin
            if (w_anyGrant) begin
                r_grantCnt[w_grantIdx] <= satInc(r_grantCnt[w_grantIdx]);
            end
            if (w_anyBlocked) begin
                r_blockedCnt <= satInc(r_blockedCnt);
            end
        end
    end

    assign grant_cnt0  = r_grantCnt[0];
    assign grant_cnt1  = r_grantCnt[1];
    assign grant_cnt2  = r_grantCnt[2];
    assign grant_cnt3  = r_grantCnt[3];
    assign blocked_cnt = r_blockedCnt;
`endif

endmodule

// File: tb/tb_qos_arbiter.sv
// ---------------------------------------------------------------------------
// tb_qos_arbiter
// Table-driven bench for qos_arbiter. Each row gives the inputs for one cycle
// and the hand-derived pop pattern; the word expected on arb_out one edge
// later is queued when the row is applied and checked after that edge.
// ---------------------------------------------------------------------------
module tb_qos_arbiter;

    localparam logic [11:0] H0  = 12'h1A5;  // dest 01
    localparam logic [11:0] H1  = 12'h2C3;  // dest 10
    localparam logic [11:0] H2  = 12'h0F0;  // dest 00
    localparam logic [11:0] H3  = 12'h3E7;  // dest 11
    localparam logic [11:0] H2B = 12'h3AB;  // dest 11

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fifo_empty;
    logic [11:0] fifo_data0, fifo_data1, fifo_data2, fifo_data3;
    logic [3:0]  dest_almost_full;
    logic [3:0]  pop;
    logic [11:0] arb_out;
    logic        arb_valid;
`ifdef QOS_ARB_STATS_EN
    logic [7:0]  grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3, blocked_cnt;
`endif

    always #5 clk = ~clk;

    qos_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .fifo_data0       (fifo_data0),
        .fifo_data1       (fifo_data1),
        .fifo_data2       (fifo_data2),
        .fifo_data3       (fifo_data3),
        .dest_almost_full (dest_almost_full),
        .pop              (pop),
        .arb_out          (arb_out),
        .arb_valid        (arb_valid)
`ifdef QOS_ARB_STATS_EN
        ,
        .grant_cnt0       (grant_cnt0),
        .grant_cnt1       (grant_cnt1),
        .grant_cnt2       (grant_cnt2),
        .grant_cnt3       (grant_cnt3),
        .blocked_cnt      (blocked_cnt)
`endif
    );

    typedef struct {
        string            name;
        logic             rst;
        logic [3:0]       empty;
        logic [3:0]       afull;
        logic [3:0][11:0] d;
        logic [3:0]       expPop;
    } vec_t;

    typedef struct {
        string       name;
        logic [11:0] word;
        logic        valid;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    function automatic vec_t mk(input string name, input logic rst,
                                input logic [3:0] empty, input logic [3:0] afull,
                                input logic [11:0] d0, input logic [11:0] d1,
                                input logic [11:0] d2, input logic [11:0] d3,
                                input logic [3:0] expPop);
        vec_t v;
        v.name   = name;
        v.rst    = rst;
        v.empty  = empty;
        v.afull  = afull;
        v.d      = {d3, d2, d1, d0};
        v.expPop = expPop;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, check the combinational pop, queue the expected
    // registered word, then check it just after the edge.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        reset            = v.rst;
        fifo_empty       = v.empty;
        dest_almost_full = v.afull;
        fifo_data0       = v.d[0];
        fifo_data1       = v.d[1];
        fifo_data2       = v.d[2];
        fifo_data3       = v.d[3];
        #1;
        checkOutput({v.name, " pop"}, 32'(pop), 32'(v.expPop));
        e.name  = v.name;
        e.word  = '0;
        e.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v.expPop[i]) begin
                e.word  = v.d[i];
                e.valid = 1'b1;
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        checkOutput({e.name, " arb_out"}, 32'(arb_out), 32'(e.word));
        checkOutput({e.name, " arb_valid"}, 32'(arb_valid), 32'(e.valid));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset            = 1'b1;
        fifo_empty       = 4'b0000;
        dest_almost_full = 4'b0000;
        fifo_data0       = H0;
        fifo_data1       = H1;
        fifo_data2       = H2;
        fifo_data3       = H3;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset pop", 32'(pop), 32'h0);
        checkOutput("reset arb_out", 32'(arb_out), 32'h0);
        checkOutput("reset arb_valid", 32'(arb_valid), 32'h0);

        // Lone VC0 after reset
        vecs.push_back(mk("rst",   1, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0000));
        vecs.push_back(mk("vc0",   0, 4'b1110, 4'b0000, H0, H1, H2, H3, 4'b0001));
        // Full rotation from reset
        vecs.push_back(mk("rst2",  1, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0000));
        vecs.push_back(mk("rr0",   0, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0001));
        vecs.push_back(mk("rr1",   0, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0010));
        vecs.push_back(mk("rr2",   0, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0100));
        vecs.push_back(mk("rr3",   0, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b1000));
        vecs.push_back(mk("rr4",   0, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0001));
        vecs.push_back(mk("rr5",   0, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0010));
        vecs.push_back(mk("rr6",   0, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0100));
        vecs.push_back(mk("rr7",   0, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b1000));
        // VC1 blocked by dest 10, VC3 served back-to-back
        vecs.push_back(mk("blk0",  0, 4'b0101, 4'b0100, H0, H1, H2, H3, 4'b1000));
        vecs.push_back(mk("blk1",  0, 4'b0101, 4'b0100, H0, H1, H2, H3, 4'b1000));
        vecs.push_back(mk("blk2",  0, 4'b0101, 4'b0100, H0, H1, H2, H3, 4'b1000));
        vecs.push_back(mk("clr0",  0, 4'b0101, 4'b0000, H0, H1, H2, H3, 4'b0010));
        vecs.push_back(mk("clr1",  0, 4'b0101, 4'b0000, H0, H1, H2, H3, 4'b1000));
        vecs.push_back(mk("clr2",  0, 4'b0101, 4'b0000, H0, H1, H2, H3, 4'b0010));
        // Idle, pointer held at VC1
        vecs.push_back(mk("idle0", 0, 4'b1111, 4'b0000, H0, H1, H2, H3, 4'b0000));
        vecs.push_back(mk("idle1", 0, 4'b1111, 4'b0000, H0, H1, H2, H3, 4'b0000));
        vecs.push_back(mk("idle2", 0, 4'b1111, 4'b0000, H0, H1, H2, H3, 4'b0000));
        vecs.push_back(mk("resume",0, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0100));
        // VC0 (dest 01) blocked while all others compete
        vecs.push_back(mk("hol0",  0, 4'b0000, 4'b0010, H0, H1, H2, H3, 4'b1000));
        vecs.push_back(mk("hol1",  0, 4'b0000, 4'b0010, H0, H1, H2, H3, 4'b0010));
        // Head change and almost-full in the same cycle
        vecs.push_back(mk("same0", 0, 4'b1011, 4'b1000, H0, H1, H2B, H3, 4'b0000));
        vecs.push_back(mk("same1", 0, 4'b1011, 4'b1000, H0, H1, H2, H3, 4'b0100));
        // Reset in the middle of traffic
        vecs.push_back(mk("midrst",1, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0000));
        vecs.push_back(mk("rel0",  0, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0001));
        vecs.push_back(mk("rel1",  0, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0010));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

`ifdef QOS_ARB_STATS_EN
        applyStimulus(mk("srst", 1, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0000));
        for (int k = 0; k < 300; k++) begin
            applyStimulus(mk("vc2run", 0, 4'b1011, 4'b0000, H0, H1, H2, H3, 4'b0100));
        end
        checkOutput("grant_cnt2 saturated", 32'(grant_cnt2), 32'd255);
        checkOutput("grant_cnt0 idle", 32'(grant_cnt0), 32'd0);
        checkOutput("grant_cnt1 idle", 32'(grant_cnt1), 32'd0);
        checkOutput("grant_cnt3 idle", 32'(grant_cnt3), 32'd0);
        checkOutput("blocked_cnt none", 32'(blocked_cnt), 32'd0);
        applyStimulus(mk("blkcnt", 0, 4'b1101, 4'b0100, H0, H1, H2, H3, 4'b0000));
        checkOutput("blocked_cnt one", 32'(blocked_cnt), 32'd1);
        applyStimulus(mk("srst2", 1, 4'b0000, 4'b0000, H0, H1, H2, H3, 4'b0000));
        checkOutput("grant_cnt2 cleared", 32'(grant_cnt2), 32'd0);
        checkOutput("blocked_cnt cleared", 32'(blocked_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/qos_arbiter.md
QOS_ARBITER -- requirements
Module: qos_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, 12, width of every data word.
REQ-002 SHALL have parameter NUM_VC, 4, number of input virtual-channel FIFOs; fixed at 4, with the destination field in bits [9:8].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port fifo_empty  input  4  per-VC empty flag, bit i for VC i.
REQ-006 SHALL have ports fifo_data0..fifo_data3  input  12 each  head word of each VC FIFO; first-word-fall-through, valid whenever the matching empty flag is 0.
REQ-007 SHALL have port dest_almost_full  input  4  almost-full flag of each downstream destination FIFO, indexed by word bits [9:8].
REQ-008 SHALL have port pop  output  4  one-hot pop strobe to the VC FIFOs; combinational.
REQ-009 SHALL have port arb_out  output  12  registered granted word, fed to the destination demux.
REQ-010 SHALL have port arb_valid  output  1  arb_out holds a new word this cycle.

Function
REQ-011 VC i is eligible in a cycle when fifo_empty[i]=0, dest_almost_full[fifo_data_i[9:8]]=0, and reset=0.
REQ-012 Grant: at most one eligible VC per cycle, chosen round-robin; search starts at last_grant+1 mod 4 and proceeds upward with wrap.
REQ-013 pop[g]=1 in the grant cycle; pop=0 when no VC is eligible.
REQ-014 Latency: on the edge that ends the grant cycle, arb_out <= fifo_data_g and arb_valid <= 1.
REQ-015 Cycles without a grant: arb_valid <= 0 and arb_out <= 0 (zero when idle, consistent with the demux zero-fill).
REQ-016 last_grant (2 bits) updates only on a grant; it holds through idle and blocked cycles.
REQ-017 A VC blocked by its destination's almost-full flag is skipped, with no head-of-line effect on other VCs; it re-enters the search once the flag clears.
REQ-018 A single eligible VC is granted every cycle (back-to-back), at one word per clock.
REQ-019 All four VCs eligible continuously: grants cycle VC0,1,2,3,0,... after reset.
REQ-020 Simultaneous almost-full assertion and head change in the same cycle: eligibility uses the current-cycle values only; no lookahead.
REQ-021 Two-state FSM: IDLE (no eligible VC), SERVE (grant this cycle).
  - IDLE->SERVE when any VC is eligible.
  - SERVE->IDLE when none is eligible.
  - The state is exported only via arb_valid one cycle later.

Reset
REQ-022 While reset=1: pop=4'b0000 (gated combinationally), arb_out=0, arb_valid=0, last_grant=3, FSM=IDLE.
REQ-023 Reset asserted mid-stream: no pop in that cycle; the word captured on the prior edge is discarded at the next edge; VC0 is first after release.

Configuration
REQ-024 Macro QOS_ARB_STATS_EN SHALL gate the statistics feature.
  - Defined: adds output grant_cnt0..grant_cnt3 (8 bits each), incremented on each grant of that VC, saturating at 255, cleared by reset.
  - Adds output blocked_cnt (8 bits), incremented each cycle in which at least one non-empty VC is ineligible due to almost-full, saturating at 255, cleared by reset.
  - Not defined: these ports and all counter logic are absent; the rest of the behaviour is identical.

Structure
REQ-025 The shared package SHALL hold:
  - constants DATA_W=12, NUM_VC=4, DEST_LSB=8, DEST_MSB=9, CNT_W=8;
  - the FSM state typedef (IDLE, SERVE).
REQ-026 The round-robin selector SHALL be one sub-module, rr_select.
  - Inputs: eligible[3:0], last_grant[1:0].
  - Outputs: grant_onehot[3:0], grant_idx[1:0], any_grant.
  - Purely combinational.

Verification
REQ-027 Reset, then VC0 only non-empty with head 12'h1A5 (dest 01), dest_almost_full=0 -> pop=0001 that cycle; next cycle arb_out=12'h1A5, arb_valid=1.
REQ-028 All VCs non-empty with destinations free for 8 cycles -> pop sequence 0001,0010,0100,1000,0001,0010,0100,1000; arb_valid=1 on every cycle from the second.
REQ-029 VC1 head 12'h2C3 (dest 10), dest_almost_full=0100, only VC1 and VC3 non-empty -> VC3 granted repeatedly, VC1 never popped; clear the flag -> VC1 granted within 2 cycles.
REQ-030 No VC non-empty for 3 cycles -> pop=0, arb_valid=0, arb_out=0; the next grant follows round-robin from the last pre-idle grant.
REQ-031 Reset asserted during continuous traffic -> pop=0 in that cycle; arb_valid=0 after the edge; first grant after release is VC0.
REQ-032 With QOS_ARB_STATS_EN: 300 consecutive VC2 grants -> grant_cnt2=255 (saturated), other grant counters 0; reset -> all counters 0.
